// File: rtl/rr_op_sequencer_if.sv
// Handshake and control bundle between the T-state sequencer and the phase-1 datapath.
// The sequencer side uses the slave modport; the stimulus/datapath side uses master.
interface rr_op_sequencer_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned OPC_W   = 5
);
  logic               Start;
  logic               Mem_ready;
  logic [DATA_W-1:0]  IR_q;
  logic               PCout;
  logic               MARin;
  logic               IncPC;
  logic               Zin;
  logic               Zlowout;
  logic               Zhighout;
  logic               PCin;
  logic               Read;
  logic               MDRin;
  logic               MDRout;
  logic               IRin;
  logic               Yin;
  logic               HIin;
  logic               LOin;
  logic [REG_CNT-1:0] Reg_out;
  logic [REG_CNT-1:0] Reg_in;
  logic [OPC_W-1:0]   ALU_op;
  logic               Busy;
  logic               Done;
  logic               Illegal;

  modport master (
    output Start, Mem_ready, IR_q,
    input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin,
    input  Yin, HIin, LOin, Reg_out, Reg_in, ALU_op, Busy, Done, Illegal
  );

  modport slave (
    input  Start, Mem_ready, IR_q,
    output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin,
    output Yin, HIin, LOin, Reg_out, Reg_in, ALU_op, Busy, Done, Illegal
  );
endinterface

// File: rtl/rr_op_sequencer.sv
// Moore T-state sequencer for register-register ALU instructions (fetch T0-T2, execute T3-T5).
// Define RR_SEQ_MULDIV_EN to add MUL/DIV with the extra T6 HI-register write.
module rr_op_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned OPC_W   = 5
) (
  input  logic          Clock,
  input  logic          Clear,
  rr_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6} state_e;

  localparam int unsigned RaLsb = DATA_W - OPC_W - SEL_W;
  localparam int unsigned RbLsb = RaLsb - SEL_W;
  localparam int unsigned RcLsb = RbLsb - SEL_W;

  localparam logic [OPC_W-1:0] OpAdd = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OpSub = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OpShr = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OpShl = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OpRor = OPC_W'(5'b00111);
  localparam logic [OPC_W-1:0] OpRol = OPC_W'(5'b01000);
  localparam logic [OPC_W-1:0] OpAnd = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OpOr  = OPC_W'(5'b01010);
`ifdef RR_SEQ_MULDIV_EN
  localparam logic [OPC_W-1:0] OpMul = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OpDiv = OPC_W'(5'b01111);
`endif

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   illegal_q, illegal_d;

  logic [OPC_W-1:0] opcode;
  logic [SEL_W-1:0] ra, rb, rc;
  logic             is_alu, is_muldiv;

  assign opcode = bus.IR_q[DATA_W-1 -: OPC_W];
  assign ra     = bus.IR_q[RaLsb +: SEL_W];
  assign rb     = bus.IR_q[RbLsb +: SEL_W];
  assign rc     = bus.IR_q[RcLsb +: SEL_W];

  // Field values at or beyond REG_CNT match no bit, leaving the bus all zero.
  function automatic logic [REG_CNT-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [REG_CNT-1:0] oh;
    for (int i = 0; i < REG_CNT; i++) begin
      oh[i] = (int'(sel) == i);
    end
    return oh;
  endfunction

  always_comb begin
    is_alu = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: is_alu = 1'b1;
      default: is_alu = 1'b0;
    endcase
  end

`ifdef RR_SEQ_MULDIV_EN
  assign is_muldiv = (opcode == OpMul) || (opcode == OpDiv);
`else
  assign is_muldiv = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      StIdle: if (bus.Start) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (bus.Mem_ready) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (is_alu || is_muldiv) begin
          state_d = StT4;
        end else begin
          state_d   = StIdle;
          illegal_d = 1'b1;
        end
      end
      StT4:   state_d = StT5;
      StT5: begin
        if (is_muldiv) begin
          state_d = StT6;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`ifdef RR_SEQ_MULDIV_EN
      StT6: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.Reg_out  = '0;
    bus.Reg_in   = '0;
    bus.ALU_op   = '0;
    case (state_q)
      StT0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      StT1: begin
        // PC loads only in the exit cycle so a stretched read does not re-load it.
        bus.Zlowout = 1'b1;
        bus.PCin    = bus.Mem_ready;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      StT3: begin
        if (is_alu || is_muldiv) begin
          bus.Reg_out = onehot(rb);
          bus.Yin     = 1'b1;
        end
      end
      StT4: begin
        bus.Reg_out = onehot(rc);
        bus.Zin     = 1'b1;
        bus.ALU_op  = opcode;
      end
      StT5: begin
        bus.Zlowout = 1'b1;
`ifdef RR_SEQ_MULDIV_EN
        if (is_muldiv) bus.LOin = 1'b1;
        else           bus.Reg_in = onehot(ra);
`else
        bus.Reg_in = onehot(ra);
`endif
      end
`ifdef RR_SEQ_MULDIV_EN
      StT6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.Busy    = (state_q != StIdle);
  assign bus.Done    = done_q;
  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_rr_op_sequencer.sv
// Directed bench for rr_op_sequencer: fetch/execute strobes, stretched read, illegal opcode,
// mid-instruction clear, back-to-back Start and (with RR_SEQ_MULDIV_EN) the MUL path.
`timescale 1ns/1ps
module tb_rr_op_sequencer;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_CNT = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned OPC_W   = 5;

  // Strobe order: PCout MARin IncPC Zin | Zlowout Zhighout PCin Read MDRin MDRout IRin Yin HIin LOin
  localparam logic [13:0] S_NONE  = 14'b0000_0000000000;
  localparam logic [13:0] S_T0    = 14'b1111_0000000000;
  localparam logic [13:0] S_T1W   = 14'b0000_1001100000;
  localparam logic [13:0] S_T1X   = 14'b0000_1011100000;
  localparam logic [13:0] S_T2    = 14'b0000_0000011000;
  localparam logic [13:0] S_T3    = 14'b0000_0000000100;
  localparam logic [13:0] S_T4    = 14'b0001_0000000000;
  localparam logic [13:0] S_T5    = 14'b0000_1000000000;
  localparam logic [13:0] S_T5MD  = 14'b0000_1000000001;
  localparam logic [13:0] S_T6    = 14'b0000_0100000010;

  localparam logic [31:0] IR_AND = 32'h4A92_0000; // AND R5, R2, R4
  localparam logic [31:0] IR_BAD = 32'hF800_0000; // opcode 11111
  localparam logic [31:0] IR_MUL = 32'h7091_8000; // MUL Ra=R1, Rb=R2, Rc=R3

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   vecs  = 0;
  int   miscompares = 0;

  rr_op_sequencer_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .OPC_W(OPC_W)) b ();

  rr_op_sequencer #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .SEL_W  (SEL_W),
    .OPC_W  (OPC_W)
  ) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus  (b.slave)
  );

  always #5 Clock = ~Clock;

  logic [13:0] strb;
  assign strb = {b.PCout, b.MARin, b.IncPC, b.Zin, b.Zlowout, b.Zhighout, b.PCin, b.Read,
                 b.MDRin, b.MDRout, b.IRin, b.Yin, b.HIin, b.LOin};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [13:0] es, input logic [15:0] eout,
                         input logic [15:0] ein, input logic [4:0] eop, input logic ebusy,
                         input logic edone, input logic eill);
    chk({tag, ".strobes"}, 32'(strb), 32'(es));
    chk({tag, ".reg_out"}, 32'(b.Reg_out), 32'(eout));
    chk({tag, ".reg_in"},  32'(b.Reg_in), 32'(ein));
    chk({tag, ".alu_op"},  32'(b.ALU_op), 32'(eop));
    chk({tag, ".busy"},    32'(b.Busy), 32'(ebusy));
    chk({tag, ".done"},    32'(b.Done), 32'(edone));
    chk({tag, ".illegal"}, 32'(b.Illegal), 32'(eill));
  endtask

  // Starts an instruction at the next edge and checks the fetch states T0..T2 (no stall).
  task automatic fetch(input string tag, input logic [31:0] ir);
    b.IR_q = ir;
    b.Mem_ready = 1'b1;
    b.Start = 1'b1;
    tick();
    b.Start = 1'b0;
    chk_all({tag, ".t0"}, S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all({tag, ".t1"}, S_T1X, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all({tag, ".t2"}, S_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    b.Start = 1'b0;
    b.Mem_ready = 1'b1;
    b.IR_q = '0;
    Clear = 1'b0;
    tick();
    tick();
    chk_all("reset", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    Clear = 1'b1;
    tick();
    chk_all("idle", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // AND R5,R2,R4: Done at k+7
    fetch("and", IR_AND);
    tick();
    chk_all("and.t3", S_T3, 16'h0004, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("and.t4", S_T4, 16'h0010, 16'h0, 5'b01001, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("and.t5", S_T5, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("and.done", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("and.after", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Mem_ready low for three T1 cycles: Done at k+10
    b.IR_q = IR_AND;
    b.Mem_ready = 1'b0;
    b.Start = 1'b1;
    tick();
    b.Start = 1'b0;
    chk_all("stall.t0", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("stall.w1", S_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("stall.w2", S_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("stall.w3", S_T1W, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    b.Mem_ready = 1'b1;
    #1;
    chk_all("stall.exit", S_T1X, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("stall.t2", S_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_all("stall.t5", S_T5, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("stall.done", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Unsupported opcode
    tick();
    fetch("bad", IR_BAD);
    tick();
    chk_all("bad.t3", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("bad.ill", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("bad.after", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Clear during T4, then restart
    fetch("clr", IR_AND);
    tick();
    tick();
    chk("clr.t4.alu_op", 32'(b.ALU_op), 32'(5'b01001));
    Clear = 1'b0;
    #1;
    chk_all("clr.async", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("clr.held", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    Clear = 1'b1;
    fetch("restart", IR_AND);
    for (int i = 0; i < 4; i++) tick();
    chk_all("restart.done", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Start held high: T0 directly follows the Done cycle
    tick();
    b.Start = 1'b1;
    tick();
    chk_all("b2b.t0a", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk_all("b2b.done1", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("b2b.t0b", S_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    b.Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_all("b2b.t5", S_T5, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("b2b.done2", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);

    // MUL
    tick();
    fetch("mul", IR_MUL);
    tick();
`ifdef RR_SEQ_MULDIV_EN
    chk_all("mul.t3", S_T3, 16'h0004, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mul.t4", S_T4, 16'h0008, 16'h0, 5'b01110, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mul.t5", S_T5MD, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mul.t6", S_T6, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mul.done", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0);
`else
    chk_all("mul.t3", S_NONE, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mul.ill", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1);
`endif
    tick();
    chk_all("final", S_NONE, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
